// File: rtl/mem_access_stage.sv
// MEM stage / MEM-WB register: drives data-memory loads and stores over req/gnt/rvalid.
// Optional feature macro MISALIGN_TRAP_EN: flag misaligned H/W accesses instead of masking them.
module mem_access_stage #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          r,
    input  logic          in_valid,
    input  logic          in_memtoreg,
    input  logic          in_regwrite,
    input  logic          in_memwrite,
    input  logic [31:0]   in_alu_result,
    input  logic [DW-1:0] in_wdata,
    input  logic [4:0]    in_rd,
    input  logic [2:0]    in_funct3,
    output logic          stall,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    output logic [3:0]    dmem_be,
    input  logic          dmem_gnt,
    input  logic          dmem_rvalid,
    input  logic [DW-1:0] dmem_rdata,
    output logic          wb_valid,
    output logic          wb_regwrite,
    output logic          wb_memtoreg,
    output logic [4:0]    wb_rd,
    output logic [DW-1:0] wb_data,
    output logic          misalign
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [DW-1:0] sdata_q, sdata_d;
    logic [31:0]   alu_q, alu_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [4:0]    rd_q, rd_d;
    logic          regwrite_q, regwrite_d;
    logic          memtoreg_q, memtoreg_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          wb_valid_q, wb_valid_d;
    logic          wb_regwrite_q, wb_regwrite_d;
    logic          wb_memtoreg_q, wb_memtoreg_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic          misalign_q, misalign_d;

    logic          mem_op;
    logic          is_byte;
    logic          is_half;
    logic          trap;
    logic [1:0]    lane_off;
    logic [3:0]    st_be;
    logic [DW-1:0] st_data;
    logic [DW-1:0] ld_shift;
    logic [DW-1:0] ld_data;

    assign mem_op  = in_valid & (in_memtoreg | in_memwrite);
    // Size comes from funct3[1:0]; the unsigned bit only matters for load extension.
    assign is_byte = (in_funct3[1:0] == 2'b00);
    assign is_half = (in_funct3[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = is_half ? in_alu_result[0] : (!is_byte && (in_alu_result[1:0] != 2'b00));
    assign trap       = mem_op & misaligned;
`else
    assign trap = 1'b0;
`endif

    // Low address bits below the access size are dropped, so misaligned accesses land aligned.
    always_comb begin
        if (is_byte) begin
            lane_off = in_alu_result[1:0];
            st_be    = 4'b0001 << in_alu_result[1:0];
            st_data  = {4{in_wdata[7:0]}};
        end else if (is_half) begin
            lane_off = {in_alu_result[1], 1'b0};
            st_be    = 4'b0011 << {in_alu_result[1], 1'b0};
            st_data  = {2{in_wdata[15:0]}};
        end else begin
            lane_off = 2'b00;
            st_be    = 4'b1111;
            st_data  = in_wdata;
        end
    end

    assign ld_shift = rdata_q >> {off_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_data = {24'd0, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_data = {16'd0, ld_shift[15:0]};
            default: ld_data = rdata_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        be_d          = be_q;
        sdata_d       = sdata_q;
        alu_d         = alu_q;
        off_d         = off_q;
        funct3_d      = funct3_q;
        rd_d          = rd_q;
        regwrite_d    = regwrite_q;
        memtoreg_d    = memtoreg_q;
        rdata_d       = rdata_q;
        wb_valid_d    = wb_valid_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_memtoreg_d = wb_memtoreg_q;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        misalign_d    = misalign_q;
        stall         = 1'b0;

        case (state_q)
            StIdle: begin
                if (mem_op && !trap) begin
                    stall      = 1'b1;
                    state_d    = StReq;
                    req_d      = 1'b1;
                    we_d       = in_memwrite;
                    addr_d     = {in_alu_result[AW-1:2], 2'b00};
                    be_d       = st_be;
                    sdata_d    = st_data;
                    alu_d      = in_alu_result;
                    off_d      = lane_off;
                    funct3_d   = in_funct3;
                    rd_d       = in_rd;
                    regwrite_d = in_regwrite;
                    memtoreg_d = in_memtoreg;
                    wb_valid_d = 1'b0;
                    misalign_d = 1'b0;
                end else begin
                    // Plain pass-through; a trapped access retires as a non-writing entry.
                    wb_valid_d    = in_valid;
                    wb_regwrite_d = in_regwrite & ~trap;
                    wb_memtoreg_d = in_memtoreg;
                    wb_rd_d       = in_rd;
                    wb_data_d     = in_alu_result;
                    misalign_d    = trap;
                end
            end
            StReq: begin
                stall      = 1'b1;
                wb_valid_d = 1'b0;
                if (dmem_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = StDone;
                    end else if (dmem_rvalid) begin
                        rdata_d = dmem_rdata;
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                stall      = 1'b1;
                wb_valid_d = 1'b0;
                if (dmem_rvalid) begin
                    rdata_d = dmem_rdata;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d       = StIdle;
                wb_valid_d    = 1'b1;
                wb_regwrite_d = regwrite_q;
                wb_memtoreg_d = memtoreg_q;
                wb_rd_d       = rd_q;
                wb_data_d     = memtoreg_q ? ld_data : alu_q;
                misalign_d    = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!r) begin
            state_q       <= StIdle;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            be_q          <= '0;
            sdata_q       <= '0;
            alu_q         <= '0;
            off_q         <= '0;
            funct3_q      <= '0;
            rd_q          <= '0;
            regwrite_q    <= 1'b0;
            memtoreg_q    <= 1'b0;
            rdata_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            sdata_q       <= sdata_d;
            alu_q         <= alu_d;
            off_q         <= off_d;
            funct3_q      <= funct3_d;
            rd_q          <= rd_d;
            regwrite_q    <= regwrite_d;
            memtoreg_q    <= memtoreg_d;
            rdata_q       <= rdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            misalign_q    <= misalign_d;
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_be     = be_q;
    assign dmem_wdata  = sdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_regwrite = wb_regwrite_q;
    assign wb_memtoreg = wb_memtoreg_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus randomized ops against an arithmetic model.
`timescale 1ns/1ps
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        r;
    logic        in_valid, in_memtoreg, in_regwrite, in_memwrite;
    logic [31:0] in_alu_result, in_wdata;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_regwrite, wb_memtoreg, misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk          (clk),
        .r            (r),
        .in_valid     (in_valid),
        .in_memtoreg  (in_memtoreg),
        .in_regwrite  (in_regwrite),
        .in_memwrite  (in_memwrite),
        .in_alu_result(in_alu_result),
        .in_wdata     (in_wdata),
        .in_rd        (in_rd),
        .in_funct3    (in_funct3),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_regwrite  (wb_regwrite),
        .wb_memtoreg  (wb_memtoreg),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .misalign     (misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: access size in bytes, naturally aligned lane offset.
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int lane_of(input logic [31:0] a, input logic [2:0] f3);
        int lo;
        lo = int'(a[1:0]);
        return lo - (lo % size_of(f3));
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [2:0] f3);
        int          n;
        logic [31:0] mask, v;
        n    = size_of(f3);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = (rd >> (8 * lane_of(a, f3))) & mask;
        if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [2:0] f3);
        int be;
        be = ((1 << size_of(f3)) - 1) << lane_of(a, f3);
        return be[3:0];
    endfunction

    function automatic logic [31:0] ref_sdata(input logic [31:0] wd, input logic [2:0] f3);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % size_of(f3)) +: 8];
        return o;
    endfunction

    // One instruction through the stage; g = gnt wait cycles, rv = cycles from gnt to rvalid.
    task automatic issue(input bit v, input bit mtr, input bit rw, input bit mw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [2:0] f3, input int g, input int rv,
                         input logic [31:0] rdat);
        bit is_mem, misal, trap, access, noise_ok, req_exp;
        int nstall;
        is_mem = v && (mtr || mw);
        misal  = (lane_of(alu, f3) != int'(alu[1:0]));
        trap   = is_mem && misal && TrapEn;
        access = is_mem && !trap;
        if (!access)  nstall = 0;
        else if (mw)  nstall = g + 2;
        else          nstall = g + 2 + rv;

        @(negedge clk);
        in_valid      = v;
        in_memtoreg   = mtr;
        in_regwrite   = rw;
        in_memwrite   = mw;
        in_alu_result = alu;
        in_wdata      = wd;
        in_rd         = rd;
        in_funct3     = f3;
        for (int k = 0; k <= nstall; k++) begin
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            noise_ok    = (k == 0) || (k == nstall);
            if (access && k == g + 1) dmem_gnt = 1'b1;
            else if (noise_ok)        dmem_gnt = 1'($urandom_range(0, 1));
            if (access && !mw && k == g + 1 + rv) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = rdat;
            end else if (noise_ok || (access && k >= 1 && k <= g)) begin
                dmem_rvalid = 1'($urandom_range(0, 1));
            end
            #1;
            check("stall", stall, 32'(k < nstall));
            req_exp = access && k >= 1 && k <= g + 1;
            check("dmem_req", dmem_req, 32'(req_exp));
            if (req_exp) begin
                check("dmem_addr", dmem_addr, {alu[31:2], 2'b00});
                check("dmem_we", dmem_we, 32'(mw));
                if (mw) begin
                    check("dmem_be", dmem_be, ref_be(alu, f3));
                    check("dmem_wdata", dmem_wdata, ref_sdata(wd, f3));
                end
            end
            if (k > 0) check("bubble_wb_valid", wb_valid, 0);
            @(posedge clk);
            if (k < nstall) @(negedge clk);
        end
        #1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (trap) begin
            check("trap_wb_valid", wb_valid, 1);
            check("trap_wb_regwrite", wb_regwrite, 0);
            check("trap_misalign", misalign, 1);
        end else begin
            check("wb_valid", wb_valid, 32'(is_mem || v));
            check("wb_regwrite", wb_regwrite, 32'(rw));
            check("wb_memtoreg", wb_memtoreg, 32'(mtr));
            check("wb_rd", wb_rd, rd);
            check("wb_data", wb_data, (is_mem && mtr) ? ref_load(rdat, alu, f3) : alu);
            check("misalign", misalign, 0);
        end
    endtask

    initial begin
        bit          v, mtr, rw, mw;
        logic [2:0]  f3;
        logic [2:0]  st_f3 [5];
        int          kind;
        st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};

        r = 1'b0;
        {in_valid, in_memtoreg, in_regwrite, in_memwrite} = '0;
        in_alu_result = '0; in_wdata = '0; in_rd = '0; in_funct3 = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_misalign", misalign, 0);
        @(negedge clk);
        r = 1'b1;

        issue(1, 0, 1, 0, 32'h0000_1234, 32'h0, 5'd5, 3'b010, 0, 0, 32'h0);
        issue(1, 0, 0, 1, 32'h0000_1003, 32'h0000_00AB, 5'd0, 3'b000, 0, 0, 32'h0);
        issue(1, 1, 1, 0, 32'h0000_2001, 32'h0, 5'd7, 3'b000, 3, 1, 32'h0000_8000);
        issue(1, 1, 1, 0, 32'h0000_2001, 32'h0, 5'd7, 3'b100, 3, 1, 32'h0000_8000);
        issue(1, 1, 1, 0, 32'h0000_4000, 32'h0, 5'd8, 3'b010, 0, 0, 32'hDEAD_BEEF);
        issue(1, 1, 1, 0, 32'h0000_3002, 32'h0, 5'd9, 3'b010, 0, 1, 32'hCAFE_F00D);

        // Reset while waiting for rvalid; the late rvalid must not retire anything.
        @(negedge clk);
        in_valid = 1'b1; in_memtoreg = 1'b1; in_memwrite = 1'b0; in_regwrite = 1'b1;
        in_alu_result = 32'h0000_5000; in_funct3 = 3'b010; in_rd = 5'd3;
        @(negedge clk);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        r = 1'b0;
        @(negedge clk);
        r = 1'b1;
        in_valid = 1'b0; in_memtoreg = 1'b0;
        #1;
        check("wait_rst_dmem_req", dmem_req, 0);
        check("wait_rst_stall", stall, 0);
        check("wait_rst_wb_valid", wb_valid, 0);
        repeat (3) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = $urandom;
            @(posedge clk);
            #1;
            check("late_rvalid_wb_valid", wb_valid, 0);
            check("late_rvalid_stall", stall, 0);
            check("late_rvalid_dmem_req", dmem_req, 0);
            @(negedge clk);
        end
        dmem_rvalid = 1'b0;

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            v    = ($urandom_range(0, 9) != 0);
            f3   = 3'($urandom_range(0, 7));
            case (kind)
                0: begin mtr = v ? 1'b0 : 1'($urandom_range(0, 1)); mw = 1'b0;
                         rw = 1'($urandom_range(0, 1)); end
                1: begin mtr = 1'b1; mw = 1'b0; rw = 1'b1; end
                default: begin mtr = 1'b0; mw = 1'b1; rw = 1'b0;
                               f3 = st_f3[$urandom_range(0, 4)]; end
            endcase
            issue(v, mtr, rw, mw, $urandom, $urandom, 5'($urandom_range(0, 31)), f3,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM stage of the 5-stage RISC-V pipeline. It consumes the EX/MEM register outputs and performs loads and stores against the data memory over a req/gnt/rvalid handshake, with byte/half/word lane handling. Its outputs are registered and feed the WB stage directly, so the block also acts as the MEM/WB register. While a memory access is in progress it drives stall, which holds the EX/MEM register and all upstream stages.

Parameters:
AW, 32, data-memory address width
DW, 32, data width (fixed lane logic assumes 32)

Ports:
clk  in  1  clock, all state on posedge
r  in  1  reset, synchronous, active-low
in_valid  in  1  EX/MEM entry holds a real instruction
in_memtoreg  in  1  load (result from memory)
in_regwrite  in  1  instruction writes rd
in_memwrite  in  1  store
in_alu_result  in  32  ALU result / effective address
in_wdata  in  32  store data (rs2)
in_rd  in  5  destination register
in_funct3  in  3  size: 000 B, 001 H, 010 W, 100 BU, 101 HU
stall  out  1  combinational; hold EX/MEM and upstream
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = write
dmem_addr  out  AW  word-aligned address {alu[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read data
wb_valid  out  1  WB entry valid
wb_regwrite  out  1  to WB
wb_memtoreg  out  1  to WB
wb_rd  out  5  to WB
wb_data  out  32  ALU result or extended load data
misalign  out  1  misaligned-access flag, aligned with wb_valid

Behaviour:
- Reset (r=0 at posedge): state IDLE, all outputs 0, in-flight access abandoned. Takes priority over every other event.
- Mem op = in_valid & (in_memtoreg | in_memwrite).
- States:
  - IDLE
    - non-mem op or in_valid=0: stall=0; next edge wb_* load the inputs; wb_data=alu_result; wb_valid=in_valid.
    - mem op: stall=1; capture addr, data, funct3, rd; goto REQ; wb_valid=0 next cycle.
  - REQ: dmem_req=1; addr/we/be/wdata held stable until gnt; stall=1.
    - gnt & store: goto DONE.
    - gnt & load & !rvalid: goto WAIT.
    - gnt & load & rvalid (same cycle): capture rdata; goto DONE.
    - rvalid without gnt: ignored.
  - WAIT: dmem_req=0; stall=1; on rvalid capture rdata, goto DONE.
  - DONE: stall=0; next edge: wb_valid=1, wb_* from captured op, state IDLE; EX/MEM advances on the same edge.
- wb_valid=0 in every cycle following a stall=1 cycle (bubble).
- Minimum stall cycles: store with immediate gnt = 2; load with immediate gnt and rvalid next cycle = 3.
- Store lanes:
  - SB: be = 0001<<a[1:0]; wdata = byte replicated x4.
  - SH: be = 0011<<{a[1],1'b0}; wdata = half replicated x2.
  - SW: be = 1111.
- Load extract: select lane by a[1:0]/a[1]; B/H sign-extend, BU/HU zero-extend, W as-is.
- Unused funct3 (011, 110, 111) is treated as word.
- Stores: wb_regwrite passes through unchanged (0 from decode).
- rvalid or gnt while in IDLE or DONE: ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - H access with a[0]=1 or W access with a[1:0]!=0, detected in IDLE.
  - No dmem request; stall=0.
  - Next edge: wb_valid=1, wb_regwrite=0, misalign=1 for one cycle.
- Undefined:
  - misalign tied 0.
  - Offending low address bits are masked to size alignment (H uses a[1], W uses lane 0) and the access proceeds normally.

Test Plan:
- ALU op: alu=0x00001234, rd=5, regwrite=1 -> next cycle wb_valid=1, wb_data=0x00001234, wb_rd=5; stall never 1.
- SB addr 0x1003, wdata 0x000000AB, gnt immediate -> dmem_addr=0x1000, be=1000, wdata=0xABABABAB, we=1; stall high 2 cycles; then wb_valid=1, wb_regwrite=0.
- LB addr 0x2001, gnt delayed 3 cycles, rdata 0x00008000 -> dmem_req held with stable addr until gnt; wb_data=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- LW addr 0x4000, gnt and rvalid same cycle, rdata 0xDEADBEEF -> stall exactly 2 cycles; wb_data=0xDEADBEEF.
- Reset in WAIT (r=0 one cycle), then rvalid pulses -> dmem_req=0, stall=0, wb_valid=0; the late rvalid does not produce a WB entry.
- LW addr 0x3002:
  - With MISALIGN_TRAP_EN: misalign=1, dmem_req never asserted, wb_regwrite=0.
  - Without: dmem_addr=0x3000, full word returned.
